sys_arr_deskew_out: RTL
=======================

Name: sys_arr_deskew_out

Overview:
Bottom-edge collector for the systolic array. It receives the staggered per-column partial sums (16-bit maccout lanes plus per-column active flags) from the last array row and removes the one-cycle-per-column skew. It packs each aligned result vector into a small FIFO and presents vectors to the downstream consumer (unified buffer writer) over a valid/ready handshake.

Parameters:
row_width, 2, number of array columns (lanes); must be >= 2
fifo_depth, 4, number of aligned result vectors buffered; power of two, >= 2
localparam sum_width = 16*row_width; cnt_width = log2(fifo_depth)+1

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear: empties FIFO and delay lines, clears sticky flags
maccin  in  sum_width  column sums from the last array row; lane i = bits [16i+15:16i]
activein  in  row_width  per-column valid from the last array row; bit i qualifies lane i
out_data  out  sum_width  aligned result vector at FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid & out_ready
count  out  cnt_width  vectors currently held
overflow  out  1  sticky: an aligned vector arrived while the FIFO was full and no pop occurred
skew_err  out  1  sticky: aligned active bits disagreed

Behaviour:
- Reset (rst_n=0, async): all delay-line regs, FIFO pointers, count, overflow, skew_err -> 0; out_valid=0; out_data=0.
- clr=1: same effect on next edge; clr has priority over push/pop that cycle.
- Skew model: a vector whose lane 0 is presented before edge k has lane i presented before edge k+i.
- Capture: every lane (sum + active) registered each edge; lane i then passes through (row_width-1-i) additional registers. Lane row_width-1 has only the capture register. All lanes of one vector are aligned at the delay outputs after edge k+row_width-1.
- Push: at edge k+row_width, if aligned active[0]=1, aligned sum vector written to FIFO tail. Latency: out_valid rises after edge k+row_width when the FIFO was empty.
- skew_err set at the push edge if aligned active bits are not all equal; vector still pushed iff active[0]=1. Lanes whose active bit is 0 are written as 0.
- Pop: out_valid & out_ready at an edge advances the head. out_data is driven from the head entry registered/array-read, stable while out_valid & !out_ready.
- Full with push and pop at the same edge: both occur, count unchanged, no overflow.
- Full with push and no pop: vector dropped, overflow set, FIFO contents untouched.
- Empty with out_ready=1: no pop, count stays 0.
- Pointers wrap modulo fifo_depth. count = pushes - pops, range 0..fifo_depth.
- Back-to-back vectors (lane 0 active every cycle) are sustained at one vector per cycle with out_ready held high.
- Delay lines run unconditionally. Downstream backpressure never stalls the array; loss is visible only via overflow.
- rst_n deassertion mid-stream: partial vectors in the delay lines are lost; no push occurs until a new lane-0 active reaches alignment.

Test Plan:
- row_width=4, out_ready=1: lane i=0x0100+i with active[i] at cycle 10+i -> out_valid high after edge 14, out_data=0x0103_0102_0101_0100, count=1 for one cycle then 0.
- 6 back-to-back skewed vectors (lane0 values 1..6), out_ready=1 -> 6 consecutive out_valid cycles, data order 1..6, overflow=0, skew_err=0.
- out_ready=0, 5 vectors, fifo_depth=4 -> count saturates at 4, overflow=1, then draining yields vectors 1..4 only, count returns 0, overflow stays 1 until clr.
- FIFO full, then a new vector with out_ready=1 at its push edge -> count stays 4, overflow=0, head advances, new vector at tail.
- Vector with active[2] missing (row_width=4) -> skew_err=1, vector pushed with lane 2 = 0x0000; clr=1 then clears skew_err, count, out_valid.
- rst_n pulsed low asynchronously mid-vector (after lanes 0-1 presented) -> outputs 0 immediately, no vector emitted from the partial data, the next full vector emitted correctly.

Source files
------------

// File: rtl/sys_arr_deskew_out_if.sv
// rtl/sys_arr_deskew_out_if.sv - result-vector stream from the deskew collector
// Master drives aligned vectors toward the buffer writer; slave applies backpressure.
interface sys_arr_deskew_out_if #(
  parameter int sum_width = 32
);
  logic [sum_width-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sys_arr_deskew_out.sv
// rtl/sys_arr_deskew_out.sv - bottom-edge deskew collector for the systolic array
// Realigns staggered column sums and queues whole result vectors for the consumer.
module sys_arr_deskew_out #(
  parameter  int row_width  = 2,
  parameter  int fifo_depth = 4,
  localparam int sum_width  = 16 * row_width,
  localparam int cnt_width  = $clog2(fifo_depth) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [sum_width-1:0]   maccin,
  input  logic [row_width-1:0]   activein,
  sys_arr_deskew_out_if.master   res,
  output logic [cnt_width-1:0]   count,
  output logic                   overflow,
  output logic                   skew_err
);

  localparam int ptr_width = $clog2(fifo_depth);

  logic [sum_width-1:0] al_sum;
  logic [row_width-1:0] al_act;
  logic [sum_width-1:0] masked_sum;

  // Lane i arrives i cycles late, so it gets i fewer stages than lane 0.
  for (genvar i = 0; i < row_width; i++) begin : g_lane
    localparam int depth = row_width - i;

    logic [15:0]      sum_q [depth];
    logic [depth-1:0] act_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < depth; j++) sum_q[j] <= '0;
        act_q <= '0;
      end else if (clr) begin
        for (int j = 0; j < depth; j++) sum_q[j] <= '0;
        act_q <= '0;
      end else begin
        sum_q[0] <= maccin[16*i +: 16];
        act_q[0] <= activein[i];
        for (int j = 1; j < depth; j++) begin
          sum_q[j] <= sum_q[j-1];
          act_q[j] <= act_q[j-1];
        end
      end
    end

    assign al_sum[16*i +: 16]     = sum_q[depth-1];
    assign al_act[i]              = act_q[depth-1];
    assign masked_sum[16*i +: 16] = act_q[depth-1] ? sum_q[depth-1] : 16'h0000;
  end

  logic                 push_req;
  logic                 act_agree;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [ptr_width-1:0] wr_ptr;
  logic [ptr_width-1:0] rd_ptr;
  logic [cnt_width-1:0] count_q;
  logic                 overflow_q;
  logic                 skew_err_q;
  logic [sum_width-1:0] mem [fifo_depth];

  // Lane 0 owns the vector: its active bit alone decides whether a push happens.
  assign push_req  = al_act[0];
  assign act_agree = (al_act == '0) || (&al_act);
  assign full      = (count_q == cnt_width'(fifo_depth));
  assign empty     = (count_q == '0);
  assign pop       = !empty && res.out_ready;
  assign push      = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= masked_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_width'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_width'(1);
      if (push && !pop)      count_q <= count_q + cnt_width'(1);
      else if (pop && !push) count_q <= count_q - cnt_width'(1);
      if (push_req && full && !pop) overflow_q <= 1'b1;
      if (push_req && !act_agree)   skew_err_q <= 1'b1;
    end
  end

  // Head is forced to zero when empty so stale entries never leak out.
  assign res.out_data  = empty ? '0 : mem[rd_ptr];
  assign res.out_valid = !empty;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign skew_err      = skew_err_q;

endmodule
